// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// 2**INDEX_BITS lines of four 32-bit words, single L2 port for refill
// and victim write-back. Hit data and stall are combinational so the
// MEM stage sees them in the same cycle as the request.
module l1_dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [31:0]  Addr,
  input  logic [31:0]  WriteData,
  output logic [31:0]  ReadData,
  output logic         CacheStall,
  output logic         l2_req,
  output logic         l2_we,
  output logic [31:0]  l2_addr,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_ready
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned TAG_W = 28 - INDEX_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [127:0]          data_arr [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      atag;
  logic [1:0]            off;
  logic [127:0]          cur_line;
  logic [TAG_W-1:0]      cur_tag;
  logic                  access;
  logic                  hit;
  logic                  wr_hit;
  logic                  fill_en;
  logic                  unused_addr_bits;

  // Address split and the addressed line's contents.
  assign idx              = Addr[3+INDEX_BITS:4];
  assign atag             = Addr[31:4+INDEX_BITS];
  assign off              = Addr[3:2];
  assign cur_line         = data_arr[idx];
  assign cur_tag          = tag_arr[idx];
  assign access           = MemRead | MemWrite;
  assign hit              = (state == IDLE) && access && valid[idx] && (cur_tag == atag);
  assign unused_addr_bits = ^Addr[1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Per-line valid/dirty bookkeeping; cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Data and tag arrays: refill replaces the line, a write hit merges one word.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_arr[idx] <= l2_rdata;
      tag_arr[idx]  <= atag;
    end else if (wr_hit) begin
      data_arr[idx][{off, 5'd0} +: 32] <= WriteData;
    end
  end

  // Next-state, array strobes and combinational outputs.
  always_comb begin
    next_state = state;
    ReadData   = '0;
    CacheStall = 1'b0;
    l2_req     = 1'b0;
    l2_we      = 1'b0;
    l2_addr    = '0;
    l2_wdata   = '0;
    wr_hit     = 1'b0;
    fill_en    = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          if (MemWrite) wr_hit   = 1'b1;
          else          ReadData = cur_line[{off, 5'd0} +: 32];
        end else if (access) begin
          CacheStall = 1'b1;
          next_state = (valid[idx] && dirty[idx]) ? WB : FILL;
        end
      end
      WB: begin
        CacheStall = 1'b1;
        l2_req     = 1'b1;
        l2_we      = 1'b1;
        l2_addr    = {cur_tag, idx, 4'b0000};
        l2_wdata   = cur_line;
        if (l2_ready) next_state = FILL;
      end
      FILL: begin
        CacheStall = 1'b1;
        l2_req     = 1'b1;
        l2_addr    = {atag, idx, 4'b0000};
        if (l2_ready) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // Reset forces every output quiet and blocks array updates.
    if (reset) begin
      ReadData   = '0;
      CacheStall = 1'b0;
      l2_req     = 1'b0;
      l2_we      = 1'b0;
      l2_addr    = '0;
      l2_wdata   = '0;
      wr_hit     = 1'b0;
      fill_en    = 1'b0;
    end
  end

endmodule
